// File: rtl/spi_arbiter.sv
// Two-requester arbiter in front of a single SPI master: grants one requester at a time (round-robin on ties),
// issues its command, tracks the selected chip-select through the transfer, and returns read bytes and completion.
module spi_arbiter #(
    parameter int START_TIMEOUT = 4,
    parameter int GUARD_CYCLES  = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_0,
    input  logic        req_1,
    input  logic [14:0] cmd_0,
    input  logic [14:0] cmd_1,
    input  logic        csel_0,
    input  logic        csel_1,
    output logic        gnt_0,
    output logic        gnt_1,
    output logic        done_0,
    output logic        done_1,
    output logic        err_0,
    output logic        err_1,
    output logic [7:0]  rd_data,
    output logic        rd_valid_0,
    output logic        rd_valid_1,
    output logic [14:0] spi_data_in,
    output logic        spi_data_in_valid,
    output logic        spi_cs_sel,
    input  logic        spi_cs0,
    input  logic        spi_cs1,
    input  logic [7:0]  spi_data_out,
    input  logic        spi_data_out_valid
);

    localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT + 1) : 1;
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [GW-1:0] GD_LAST = GW'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_START,
        S_BUSY,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         r_state;
    logic           r_owner;
    logic           r_ptr;       // last requester served; reset to 1 so requester 0 wins the first tie
    logic [TW-1:0]  r_timer;
    logic [GW-1:0]  r_guard;
    logic [1:0]     r_gnt;
    logic [1:0]     r_done;
    logic [1:0]     r_err;
    logic [1:0]     r_rd_valid;
    logic [7:0]     r_rd_data;
    logic [14:0]    r_data_in;
    logic           r_data_in_valid;
    logic           r_cs_sel;

    logic           w_any_req;
    logic           w_pick;
    logic [14:0]    w_cmd;
    logic           w_csel;
    logic           w_sel_cs;
    logic           w_capture;
    logic [1:0]     w_owner_oh;

    assign w_any_req  = req_0 | req_1;
    assign w_pick     = (req_0 & req_1) ? ~r_ptr : req_1;
    assign w_cmd      = w_pick ? cmd_1 : cmd_0;
    assign w_csel     = w_pick ? csel_1 : csel_0;
    assign w_sel_cs   = r_cs_sel ? spi_cs1 : spi_cs0;
    assign w_owner_oh = r_owner ? 2'b10 : 2'b01;
    assign w_capture  = spi_data_out_valid &&
                        (r_state == S_START || r_state == S_BUSY || r_state == S_DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_owner         <= 1'b0;
            r_ptr           <= 1'b1;
            r_timer         <= '0;
            r_guard         <= '0;
            r_gnt           <= 2'b00;
            r_done          <= 2'b00;
            r_err           <= 2'b00;
            r_rd_valid      <= 2'b00;
            r_rd_data       <= 8'h00;
            r_data_in       <= 15'h0000;
            r_data_in_valid <= 1'b0;
            r_cs_sel        <= 1'b0;
        end else begin
            r_rd_valid <= 2'b00;
            if (w_capture) begin
                r_rd_data  <= spi_data_out;
                r_rd_valid <= w_owner_oh;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner         <= w_pick;
                        r_gnt           <= w_pick ? 2'b10 : 2'b01;
                        r_data_in       <= w_cmd;
                        r_data_in_valid <= 1'b1;
                        r_cs_sel        <= w_csel;
                        r_state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_data_in_valid <= 1'b0;
                    r_timer         <= '0;
                    r_state         <= S_START;
                end
                S_START: begin
                    if (!w_sel_cs) begin
                        r_state <= S_BUSY;
                    end else if (r_timer == TO_LAST) begin
                        r_done  <= w_owner_oh;
                        r_err   <= w_owner_oh;
                        r_state <= S_DONE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_BUSY: begin
                    if (w_sel_cs) begin
                        r_guard <= '0;
                        r_state <= S_DRAIN;
                    end
                end
                // CS activity is deliberately ignored here: the master's tail may still toggle it.
                S_DRAIN: begin
                    if (r_guard == GD_LAST) begin
                        r_done  <= w_owner_oh;
                        r_state <= S_DONE;
                    end else begin
                        r_guard <= r_guard + GW'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 2'b00;
                    r_err   <= 2'b00;
                    r_gnt   <= 2'b00;
                    r_ptr   <= r_owner;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt_0             = r_gnt[0];
    assign gnt_1             = r_gnt[1];
    assign done_0            = r_done[0];
    assign done_1            = r_done[1];
    assign err_0             = r_err[0];
    assign err_1             = r_err[1];
    assign rd_valid_0        = r_rd_valid[0];
    assign rd_valid_1        = r_rd_valid[1];
    assign rd_data           = r_rd_data;
    assign spi_data_in       = r_data_in;
    assign spi_data_in_valid = r_data_in_valid;
    assign spi_cs_sel        = r_cs_sel;

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: stimulus pushes expected events (issue, read, done) with their
// cycle stamps; a negedge monitor pops and compares whenever the DUT presents one.
module tb_spi_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_0, req_1;
    logic [14:0] cmd_0, cmd_1;
    logic        csel_0, csel_1;
    logic        gnt_0, gnt_1, done_0, done_1, err_0, err_1;
    logic [7:0]  rd_data;
    logic        rd_valid_0, rd_valid_1;
    logic [14:0] spi_data_in;
    logic        spi_data_in_valid, spi_cs_sel;
    logic        spi_cs0, spi_cs1;
    logic [7:0]  spi_data_out;
    logic        spi_data_out_valid;

    always #5 clk = ~clk;

    spi_arbiter #(.START_TIMEOUT(4), .GUARD_CYCLES(20)) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .req_1(req_1), .cmd_0(cmd_0), .cmd_1(cmd_1),
        .csel_0(csel_0), .csel_1(csel_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1), .done_0(done_0), .done_1(done_1),
        .err_0(err_0), .err_1(err_1), .rd_data(rd_data),
        .rd_valid_0(rd_valid_0), .rd_valid_1(rd_valid_1),
        .spi_data_in(spi_data_in), .spi_data_in_valid(spi_data_in_valid),
        .spi_cs_sel(spi_cs_sel), .spi_cs0(spi_cs0), .spi_cs1(spi_cs1),
        .spi_data_out(spi_data_out), .spi_data_out_valid(spi_data_out_valid)
    );

    // kind: 0 = command issue, 1 = read byte, 2 = done (dat holds err)
    typedef struct {
        int          kind;
        int          owner;
        logic [14:0] dat;
        logic        sel;
        int          cyc;
    } ev_t;

    ev_t exp_q[$];
    int  vectors = 0;
    int  fails   = 0;
    int  cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_ev(input int kind, input int owner, input logic [14:0] dat, input logic sel);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: kind=%0d owner=%0d dat=%h sel=%0d cyc=%0d, none expected",
                     kind, owner, dat, sel, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.owner != owner || e.dat != dat || e.sel != sel || e.cyc != cyc) begin
                fails++;
                $display("FAIL event: got kind=%0d owner=%0d dat=%h sel=%0d cyc=%0d, expected kind=%0d owner=%0d dat=%h sel=%0d cyc=%0d",
                         kind, owner, dat, sel, cyc, e.kind, e.owner, e.dat, e.sel, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (gnt_0 && gnt_1) begin
                fails++;
                $display("FAIL gnt_overlap: both grants high at cycle %0d", cyc);
            end
            if ((done_0 && done_1) || (rd_valid_0 && rd_valid_1)) begin
                fails++;
                $display("FAIL pulse_overlap: done=%b%b rd_valid=%b%b at cycle %0d",
                         done_1, done_0, rd_valid_1, rd_valid_0, cyc);
            end
            if ((err_0 && !done_0) || (err_1 && !done_1)) begin
                fails++;
                $display("FAIL err_without_done: err=%b%b done=%b%b at cycle %0d",
                         err_1, err_0, done_1, done_0, cyc);
            end
            if (spi_data_in_valid)
                check_ev(0, gnt_1 ? 1 : 0, spi_data_in, spi_cs_sel);
            if (rd_valid_0 || rd_valid_1)
                check_ev(1, rd_valid_1 ? 1 : 0, {7'd0, rd_data}, spi_cs_sel);
            if (done_0 || done_1)
                check_ev(2, done_1 ? 1 : 0, {14'd0, (done_1 ? err_1 : err_0)}, spi_cs_sel);
        end
    end

    task automatic set_cs(input logic sel, input logic v);
        if (sel) spi_cs1 = v;
        else     spi_cs0 = v;
    endtask

    // kind: 0 = write-like transfer, 1 = transfer returning byte rb, 2 = selected CS never falls
    task automatic do_txn(input int o, input logic [14:0] cmd, input logic sel, input int kind,
                          input logic [7:0] rb);
        int c;
        int k;
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if ((o == 0 && gnt_0) || (o == 1 && gnt_1)) begin
                got = 1'b1;
                break;
            end
        end
        vectors++;
        if (!got) begin
            fails++;
            $display("FAIL grant_wait: owner %0d got no grant within 60 cycles", o);
            req_0 = 1'b0;
            req_1 = 1'b0;
            return;
        end
        c = cyc;
        exp_q.push_back('{0, o, cmd, sel, c});
        if (o == 0) req_0 = 1'b0;
        else        req_1 = 1'b0;
        if (kind == 2) begin
            exp_q.push_back('{2, o, 15'd1, sel, c + 5});
            tick();
            set_cs(!sel, 1'b0);
            repeat (5) tick();
            set_cs(!sel, 1'b1);
        end else begin
            tick();
            set_cs(!sel, 1'b0);
            tick();
            tick();
            set_cs(sel, 1'b0);
            tick();
            set_cs(!sel, 1'b1);
            tick();
            if (kind == 1) begin
                spi_data_out       = rb;
                spi_data_out_valid = 1'b1;
                exp_q.push_back('{1, o, {7'd0, rb}, sel, cyc + 1});
                tick();
                spi_data_out_valid = 1'b0;
                spi_data_out       = 8'h00;
            end
            tick();
            set_cs(sel, 1'b1);
            k = cyc;
            exp_q.push_back('{2, o, 15'd0, sel, k + 21});
            repeat (3) tick();
            set_cs(sel, 1'b0);
            repeat (2) tick();
            set_cs(sel, 1'b1);
            while (cyc < k + 22) tick();
        end
        chk("gnt_drop", (o == 0) ? gnt_0 : gnt_1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_0 = 1'b0; req_1 = 1'b0;
        cmd_0 = 15'h0; cmd_1 = 15'h0;
        csel_0 = 1'b0; csel_1 = 1'b0;
        spi_cs0 = 1'b1; spi_cs1 = 1'b1;
        spi_data_out = 8'h00; spi_data_out_valid = 1'b0;
        repeat (3) tick();
        chk("rst_gnt", {gnt_1, gnt_0}, 0);
        chk("rst_done_err", {done_1, done_0, err_1, err_0}, 0);
        chk("rst_rd", {rd_valid_1, rd_valid_0, rd_data}, 0);
        chk("rst_spi_in", {spi_data_in_valid, spi_data_in}, 0);
        chk("rst_cs_sel", spi_cs_sel, 0);
        rst = 1'b0;

        // simultaneous requests twice in a row: expect 0,1,0,1
        req_0 = 1'b1; cmd_0 = 15'h0011; csel_0 = 1'b0;
        req_1 = 1'b1; cmd_1 = 15'h0122; csel_1 = 1'b0;
        do_txn(0, 15'h0011, 1'b0, 0, 8'h00);
        do_txn(1, 15'h0122, 1'b0, 0, 8'h00);
        req_0 = 1'b1; cmd_0 = 15'h0213; csel_0 = 1'b1;
        req_1 = 1'b1; cmd_1 = 15'h0324; csel_1 = 1'b0;
        do_txn(0, 15'h0213, 1'b1, 0, 8'h00);
        do_txn(1, 15'h0324, 1'b0, 0, 8'h00);

        // plain write on CS0, then a lone request 0 again with pointer at 0
        req_0 = 1'b1; cmd_0 = 15'h0002; csel_0 = 1'b0;
        do_txn(0, 15'h0002, 1'b0, 0, 8'h00);
        req_0 = 1'b1; cmd_0 = 15'h0006; csel_0 = 1'b0;
        do_txn(0, 15'h0006, 1'b0, 0, 8'h00);

        // read on CS1 returning A5
        req_1 = 1'b1; cmd_1 = 15'h0001; csel_1 = 1'b1;
        do_txn(1, 15'h0001, 1'b1, 1, 8'hA5);

        // data_out_valid while idle must be discarded
        spi_data_out = 8'h3C; spi_data_out_valid = 1'b1;
        tick();
        spi_data_out_valid = 1'b0; spi_data_out = 8'h00;
        tick();
        chk("rd_data_hold", rd_data, 8'hA5);

        // start timeouts on each owner
        req_1 = 1'b1; cmd_1 = 15'h0010; csel_1 = 1'b0;
        do_txn(1, 15'h0010, 1'b0, 2, 8'h00);
        req_0 = 1'b1; cmd_0 = 15'h7FFF; csel_0 = 1'b1;
        do_txn(0, 15'h7FFF, 1'b1, 2, 8'h00);

        // reset while BUSY, then a normal transaction for requester 1
        req_0 = 1'b1; cmd_0 = 15'h0003; csel_0 = 1'b0;
        tick();
        exp_q.push_back('{0, 0, 15'h0003, 1'b0, cyc});
        chk("mid_rst_gnt", gnt_0, 1);
        req_0 = 1'b0;
        tick();
        spi_cs0 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_gnt_all", {gnt_1, gnt_0}, 0);
        chk("mid_rst_done_err", {done_1, done_0, err_1, err_0}, 0);
        chk("mid_rst_rd", {rd_valid_1, rd_valid_0, rd_data}, 0);
        chk("mid_rst_spi", {spi_cs_sel, spi_data_in_valid, spi_data_in}, 0);
        rst = 1'b0;
        spi_cs0 = 1'b1;
        req_1 = 1'b1; cmd_1 = 15'h4001; csel_1 = 1'b1;
        do_txn(1, 15'h4001, 1'b1, 0, 8'h00);

        repeat (5) tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter: START_TIMEOUT, 4, max cycles in START waiting for selected CS low before abort.
REQ-002 Parameter: GUARD_CYCLES, 20, cycles held in DRAIN after selected CS rises, covering master tail (DATA up to cnt 17, DATA_INC up to cnt 9).
REQ-003 Clock: one clock, clk; reset: rst, synchronous, active-high.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_0, req_1  input  1 each  transaction request, level, held until gnt_x.
REQ-007 cmd_0, cmd_1  input  15 each  SPI command word; bits[1:0] mode as used by SPI master.
REQ-008 csel_0, csel_1  input  1 each  target slave select (0 -> CS0, 1 -> CS1).
REQ-009 gnt_0, gnt_1  output  1 each  high from grant until end of DONE.
REQ-010 done_0, done_1  output  1 each  one-cycle completion pulse.
REQ-011 err_0, err_1  output  1 each  one-cycle pulse coincident with done_x on start timeout.
REQ-012 rd_data  output  8  read byte, shared.
REQ-013 rd_valid_0, rd_valid_1  output  1 each  one-cycle pulse qualifying rd_data for owner.
REQ-014 spi_data_in  output  15  to master Data_in; spi_data_in_valid  output  1  to master data_in_valid.
REQ-015 spi_cs_sel  output  1  to master CS_Sel; spi_cs0, spi_cs1  input  1  from master CS0/CS1.
REQ-016 spi_data_out  input  8, spi_data_out_valid  input  1  from master Data_out/data_out_valid.

Function
REQ-017 FSM states IDLE, ISSUE, START, BUSY, DRAIN, DONE; reset state IDLE.
REQ-018 IDLE: on any req_x, latch owner, cmd, csel; assert gnt_owner next cycle; go ISSUE.
REQ-019 Both req high in same IDLE cycle: grant requester not served last (round-robin pointer); pointer reset so requester 0 wins first tie.
REQ-020 Single req wins regardless of pointer; pointer updated only in DONE.
REQ-021 ISSUE: exactly one cycle spi_data_in_valid=1, spi_data_in=latched cmd; go START, timer cleared.
REQ-022 spi_cs_sel driven from latched csel from ISSUE through DONE, constant; IDLE value holds last csel (reset 0).
REQ-023 START: selected CS (spi_cs0 if csel=0 else spi_cs1) low -> BUSY; timer reaching START_TIMEOUT with CS still high -> DONE with error flag.
REQ-024 BUSY: selected CS high -> DRAIN, guard counter cleared.
REQ-025 DRAIN: count GUARD_CYCLES cycles, then DONE; CS falling again in DRAIN ignored.
REQ-026 In START, BUSY, DRAIN: spi_data_out_valid=1 -> next cycle rd_data=spi_data_out, rd_valid_owner=1 for one cycle; other rd_valid stays 0.
REQ-027 spi_data_out_valid in IDLE, ISSUE, DONE discarded; rd_data holds last value otherwise.
REQ-028 DONE: one cycle; done_owner=1, err_owner=1 only if timeout; gnt_owner drops next cycle; pointer=owner; go IDLE.
REQ-029 req_x seen during DONE ignored; evaluated in following IDLE cycle (minimum 1 IDLE cycle between transactions).
REQ-030 Counters sized for parameters, saturate never needed; no wrap within a state.
REQ-031 At most one gnt, one done, one rd_valid high in any cycle.

Reset
REQ-032 rst=1 at rising edge: state IDLE, all outputs 0 (gnt, done, err, rd_valid, rd_data, spi_data_in, spi_data_in_valid, spi_cs_sel), pointer favours requester 0.
REQ-033 rst mid-transaction: abort immediately, no done/err pulse; in-flight master transfer not tracked after reset.

Verification
REQ-034 req_0, cmd_0=15'h0002 (write), csel_0=0 -> gnt_0, one-cycle spi_data_in_valid with 15'h0002, spi_cs0 low, done_0 pulse GUARD_CYCLES+1 cycles after spi_cs0 rises, err_0=0.
REQ-035 req_0 and req_1 same cycle, twice back-to-back -> order 0,1 then 1? no: order 0,1,0,1; gnt never overlap.
REQ-036 Read: master returns data_out_valid with 8'hA5 in BUSY -> rd_data=8'hA5, rd_valid_1 next cycle for owner 1, rd_valid_0=0.
REQ-037 Selected CS never falls -> done_x and err_x pulse together START_TIMEOUT+1 cycles after ISSUE, back to IDLE.
REQ-038 csel_1=1 transaction: spi_cs_sel=1 throughout, spi_cs0 activity ignored, completion on spi_cs1 only.
REQ-039 rst asserted in BUSY -> next cycle all outputs 0, state IDLE, no done pulse; new req_1 granted normally.
